// File: rtl/dds_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dds_ctrl_pkg
// Shared definitions for the DDS frequency-sweep controller:
//   - default widths for the phase/tuning word, step/dwell fields and the
//     in-flight sample counter
//   - the sweep FSM state type
// Optional feature macro used by this codebase slice: DDS_SWEEP_REPEAT_EN
// ---------------------------------------------------------------------------
package dds_ctrl_pkg;

    localparam int DDS_PHASE_W = 25;  // DDS phase_i / sine_o / cosine_o width
    localparam int DDS_CNT_W   = 16;  // step-count and dwell field width
    localparam int DDS_OUT_W   = 8;   // in-flight sample counter width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sweep_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// ---------------------------------------------------------------------------
// dds_phase_acc
// Phase accumulator, current tuning word and dwell counter of the sweep.
// Strobes come from the sweep FSM in dds_sweep_ctrl.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   load             latch f_start/f_step/dwell, clear acc, freq <= f_start
//   enable           one sample issued: acc += freq, advance dwell counter
//   step             (with enable) last sample of a step: freq += f_step
//   rewind           (with enable) repeat restart: freq <= latched f_start
//   f_start, f_step  tuning-word configuration (sampled on load only)
//   dwell            samples per step (0 treated as 1)
//   acc              accumulator, presented as the DDS phase
//   dwell_last       current sample is the last one of its step
// ---------------------------------------------------------------------------
module dds_phase_acc
    import dds_ctrl_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W,
    parameter int CNT_W   = DDS_CNT_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load,
    input  logic               enable,
    input  logic               step,
    input  logic               rewind,
    input  logic [PHASE_W-1:0] f_start,
    input  logic [PHASE_W-1:0] f_step,
    input  logic [CNT_W-1:0]   dwell,
    output logic [PHASE_W-1:0] acc,
    output logic               dwell_last
);

    logic [PHASE_W-1:0] f_start_q;
    logic [PHASE_W-1:0] f_step_q;
    logic [PHASE_W-1:0] freq;
    logic [CNT_W-1:0]   dwell_max;   // dwell - 1, with dwell 0 folded to 1
    logic [CNT_W-1:0]   dwell_cnt;

    assign dwell_last = (dwell_cnt == dwell_max);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_start_q <= '0;
            f_step_q  <= '0;
            freq      <= '0;
            dwell_max <= '0;
            dwell_cnt <= '0;
            acc       <= '0;
        end else if (load) begin
            f_start_q <= f_start;
            f_step_q  <= f_step;
            freq      <= f_start;
            dwell_max <= (dwell == '0) ? '0 : dwell - CNT_W'(1);
            dwell_cnt <= '0;
            acc       <= '0;
        end else if (enable) begin
            // Modulo-2^PHASE_W wrap is the natural overflow of the adder.
            acc       <= acc + freq;
            dwell_cnt <= dwell_last ? '0 : dwell_cnt + CNT_W'(1);
            if (rewind) begin
                freq <= f_start_q;
            end else if (step) begin
                freq <= freq + f_step_q;
            end
        end
    end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
// Frequency-sweep controller feeding a DDS core. A sweep issues one phase
// sample per cycle, holds each tuning word for 'dwell' samples, steps it
// 'step_count' times, then waits for the DDS pipeline to drain.
//
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   start_i                start a sweep (accepted in IDLE only)
//   abort_i                stop the running sweep early
//   f_start_i, f_step_i    first tuning word, increment per step
//   step_count_i, dwell_i  steps per sweep, samples per step (0 means 1)
//   repeat_i               (DDS_SWEEP_REPEAT_EN only) restart the sweep
//                          seamlessly at end-of-sweep
//   phase_o, phase_valid_o to DDS phase_i / phase_valid_i
//   data_valid_i           from DDS data_valid_o
//   busy_o                 sweep running or draining
//   done_o                 one-cycle pulse when a sweep has fully drained
//   step_idx_o             index of the current step
//   err_o                  sticky: unexpected data_valid_i or in-flight
//                          overflow; cleared on reset or accepted start
//
// Optional feature macro: DDS_SWEEP_REPEAT_EN (adds repeat_i).
// ---------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int PHASE_W = DDS_PHASE_W,
    parameter int CNT_W   = DDS_CNT_W,
    parameter int OUT_W   = DDS_OUT_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [PHASE_W-1:0] f_start_i,
    input  logic [PHASE_W-1:0] f_step_i,
    input  logic [CNT_W-1:0]   step_count_i,
    input  logic [CNT_W-1:0]   dwell_i,
`ifdef DDS_SWEEP_REPEAT_EN
    input  logic               repeat_i,
`endif
    input  logic               data_valid_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               phase_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   step_idx_o,
    output logic               err_o
);

    localparam logic [OUT_W-1:0] INFLIGHT_MAX = '1;

    sweep_state_e     state;
    logic [CNT_W-1:0] step_last;     // step_count - 1, with 0 folded to 1
    logic [OUT_W-1:0] inflight;
    logic [OUT_W-1:0] inflight_d;
    logic             err_d;

    logic repeat_en;
    logic in_run;
    logic dwell_last;
    logic sweep_end;
    logic load;
    logic enable;
    logic step;
    logic rewind;

`ifdef DDS_SWEEP_REPEAT_EN
    assign repeat_en = repeat_i;
`else
    assign repeat_en = 1'b0;
`endif

    // Strobes for the accumulator. The final sample of a one-shot sweep and
    // an aborted sample do not advance acc, so phase_o keeps the last value
    // actually presented to the DDS.
    always_comb begin
        in_run    = (state == ST_RUN);
        load      = (state == ST_IDLE) && start_i;
        sweep_end = in_run && dwell_last && (step_idx_o == step_last);
        enable    = in_run && !abort_i && !(sweep_end && !repeat_en);
        step      = enable && dwell_last && !sweep_end;
        rewind    = enable && sweep_end;
    end

    dds_phase_acc #(
        .PHASE_W (PHASE_W),
        .CNT_W   (CNT_W)
    ) u_phase_acc (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load       (load),
        .enable     (enable),
        .step       (step),
        .rewind     (rewind),
        .f_start    (f_start_i),
        .f_step     (f_step_i),
        .dwell      (dwell_i),
        .acc        (phase_o),
        .dwell_last (dwell_last)
    );

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            phase_valid_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            step_idx_o    <= '0;
            step_last     <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state         <= ST_RUN;
                        phase_valid_o <= 1'b1;
                        busy_o        <= 1'b1;
                        step_idx_o    <= '0;
                        step_last     <= (step_count_i == '0) ? '0
                                                              : step_count_i - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Abort is tested first so it wins over a coincident end.
                    if (abort_i || (sweep_end && !repeat_en)) begin
                        state         <= ST_DRAIN;
                        phase_valid_o <= 1'b0;
                    end else if (sweep_end) begin
                        step_idx_o <= '0;
                    end else if (dwell_last) begin
                        step_idx_o <= step_idx_o + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (inflight == '0) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // In-flight tracking: +1 per issued sample, -1 per returned sample,
    // unchanged when both happen together; saturates at the top.
    // NOTE: defaults at the top of the block give every path a value, so no
    // latch is inferred.
    always_comb begin
        inflight_d = inflight;
        err_d      = err_o;
        if (phase_valid_o && !data_valid_i) begin
            if (inflight == INFLIGHT_MAX) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight + OUT_W'(1);
            end
        end else if (data_valid_i && !phase_valid_o && (inflight != '0)) begin
            inflight_d = inflight - OUT_W'(1);
        end
        if (data_valid_i && (inflight == '0)) begin
            err_d = 1'b1;
        end
        if (load) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight <= '0;
            err_o    <= 1'b0;
        end else begin
            inflight <= inflight_d;
            err_o    <= err_d;
        end
    end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_W, 25, phase and tuning-word width matching the DDS phase_i/sine_o/cosine_o width.
REQ-002 SHALL have parameter CNT_W, 16, width of step-count and dwell fields.
REQ-003 SHALL have parameter OUT_W, 8, width of the in-flight sample counter.
REQ-004 SHALL have port clk_i input 1, single clock; reset is asynchronous and active-low on rst_n_i.
REQ-005 SHALL have port rst_n_i input 1, asynchronous active-low reset.
REQ-006 SHALL have ports start_i input 1, start a sweep (pulse); abort_i input 1, stop the sweep early.
REQ-007 SHALL have ports f_start_i input PHASE_W, first tuning word; f_step_i input PHASE_W, tuning-word increment per step.
REQ-008 SHALL have ports step_count_i input CNT_W, number of steps; dwell_i input CNT_W, samples per step.
REQ-009 SHALL have ports phase_o output PHASE_W and phase_valid_o output 1, driving the DDS phase_i and phase_valid_i.
REQ-010 SHALL have port data_valid_i input 1, connected to the DDS data_valid_o.
REQ-011 SHALL have ports busy_o output 1, done_o output 1 (one-cycle pulse), step_idx_o output CNT_W, err_o output 1 (sticky).

Function
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE: start_i=1 SHALL latch f_start_i, f_step_i, step_count_i and dwell_i, clear the accumulator, clear step_idx_o, and move to RUN on the next edge.
REQ-014 start_i SHALL be ignored outside IDLE; config inputs SHALL be sampled only at start.
REQ-015 RUN: phase_valid_o=1 every cycle; phase_o=acc; acc <= (acc + freq) mod 2^PHASE_W, with silent wrap-around.
REQ-016 freq SHALL equal f_start on the first RUN cycle; after every dwell samples, freq <= (freq + f_step) mod 2^PHASE_W and step_idx_o increments.
REQ-017 After step_count samples-steps complete, the FSM SHALL move to DRAIN with no extra phase_valid_o cycle; dwell=0 and step_count=0 SHALL each be treated as 1.
REQ-018 abort_i=1 in RUN SHALL force DRAIN next cycle, with phase_valid_o low from that cycle; abort_i SHALL win over a simultaneous end-of-sweep.
REQ-019 The in-flight counter SHALL increment on phase_valid_o, decrement on data_valid_i, hold when both are active, and saturate at 2^OUT_W-1.
REQ-020 DRAIN: phase_valid_o=0; the FSM SHALL move to DONE when in-flight==0, and SHALL not wait when in-flight is already 0 on entry.
REQ-021 DONE SHALL last one cycle with done_o=1, then return to IDLE.
REQ-022 busy_o SHALL be 1 in RUN and DRAIN, 0 otherwise.
REQ-023 err_o SHALL set on data_valid_i with in-flight==0 or on an increment at saturation, and SHALL clear only on reset or on start acceptance.
REQ-024 In IDLE and DONE, phase_o SHALL hold its last value and phase_valid_o SHALL be 0.

Reset
REQ-025 rst_n_i low SHALL immediately force IDLE, phase_o=0, phase_valid_o=0, busy_o=0, done_o=0, step_idx_o=0, err_o=0, in-flight=0, acc=0, freq=0.
REQ-026 Reset mid-RUN or mid-DRAIN SHALL discard the sweep with no done_o pulse.

Configuration
REQ-027 With macro DDS_SWEEP_REPEAT_EN defined, the block SHALL add port repeat_i input 1; if repeat_i=1 at end-of-sweep, freq SHALL reload f_start, step_idx_o SHALL reset to 0, and RUN SHALL continue without a gap and without done_o, while acc is not cleared.
REQ-028 Without DDS_SWEEP_REPEAT_EN, repeat_i SHALL be absent and every sweep SHALL be one-shot.

Structure
REQ-029 Package dds_ctrl_pkg SHALL hold PHASE_W and CNT_W defaults and the FSM state enum type.
REQ-030 Sub-module dds_phase_acc SHALL hold acc/freq/dwell counting, controlled by load, enable and step strobes from the FSM.

Verification
REQ-031 f_start=0x100000, f_step=0, steps=1, dwell=4 -> exactly 4 phase_valid_o cycles with phase_o 0x000000, 0x100000, 0x200000, 0x300000; done_o once after the matching data_valid_i.
REQ-032 f_start=0x1000000, f_step=0x10, steps=3, dwell=2 -> 6 samples; freq 0x1000000, 0x1000010, 0x1000020; phase_o wraps modulo 2^25; step_idx_o 0,1,2.
REQ-033 abort_i at the 3rd RUN cycle, DDS model latency 5 -> phase_valid_o low from cycle 4; done_o only after all 3 data_valid_i have arrived.
REQ-034 Reset asserted in DRAIN with 2 samples in flight -> all outputs 0 asynchronously, no done_o; a new start works normally.
REQ-035 Spurious data_valid_i in IDLE -> err_o=1 and held; next start clears it.
REQ-036 DDS_SWEEP_REPEAT_EN, repeat_i=1, steps=2, dwell=1 -> continuous freq pattern f_start, f_start+f_step, f_start, ...; no done_o until repeat_i=0.
